// File: rtl/niosii_system_key_pio.sv
// Push-button input PIO with Avalon-MM slave access.
// Each key bit is synchronised, debounced, edge-detected and latched into a
// software-clearable edge-capture register that drives a maskable level irq.
//
// Ports:
//   clk, reset_n         system clock, asynchronous active-low reset
//   address[1:0]         word address: 0 data, 1 reserved, 2 irqmask, 3 edge_capture
//   chipselect, write_n  bus select and active-low write strobe
//   writedata[31:0]      write data
//   in_port[WIDTH-1:0]   raw asynchronous key inputs
//   readdata[31:0]       combinational read data from registers
//   irq                  registered level interrupt, active high
module niosii_system_key_pio #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 1,
    parameter bit          IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, prev_q;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irqmask_q, edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] clear_bits;
    logic             bus_wr;
    logic             irq_q;
    logic             unused_wdata;

    // Two-flop synchroniser for the asynchronous key inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= IDLE;
            sync2_q <= IDLE;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stable_q <= IDLE;
            end else begin
                stable_q <= sync2_q;
            end
        end
    end else begin : g_filter
        localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] cnt_q [WIDTH];

        // A changed input must differ from stable for DEBOUNCE_CYCLES
        // consecutive cycles; any return to stable restarts the count.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stable_q <= IDLE;
                for (int i = 0; i < int'(WIDTH); i++) begin
                    cnt_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    if (sync2_q[i] == stable_q[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        stable_q[i] <= sync2_q[i];
                        cnt_q[i]    <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        if (EDGE_TYPE == 0) begin
            edge_det = ~prev_q & stable_q;
        end else if (EDGE_TYPE == 1) begin
            edge_det = prev_q & ~stable_q;
        end else begin
            edge_det = prev_q ^ stable_q;
        end
    end

    assign bus_wr       = chipselect & ~write_n;
    assign clear_bits   = (bus_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    // A new edge overrides a clear of the same bit in the same cycle.
    assign edge_capture_d = (edge_capture_q & ~clear_bits) | edge_det;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q         <= IDLE;
            edge_capture_q <= '0;
            irqmask_q      <= '0;
            irq_q          <= 1'b0;
        end else begin
            prev_q         <= stable_q;
            edge_capture_q <= edge_capture_d;
            if (bus_wr && address == 2'd2) begin
                irqmask_q <= writedata[WIDTH-1:0];
            end
            // Built from registers only, so the bus never reaches irq combinationally.
            irq_q <= |(edge_capture_q & irqmask_q);
        end
    end

    assign irq = irq_q;

    always_comb begin
        readdata = '0;
        unique case (address)
            2'd0:    readdata = 32'(stable_q);
            2'd2:    readdata = 32'(irqmask_q);
            2'd3:    readdata = 32'(edge_capture_q);
            default: readdata = '0;
        endcase
    end

    assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_niosii_system_key_pio.sv
// Directed self-checking bench for niosii_system_key_pio
// (WIDTH=4, DEBOUNCE_CYCLES=4, falling-edge capture, idle-high keys).
module tb_niosii_system_key_pio;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int tests = 0;
    int fails = 0;

    niosii_system_key_pio #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (1),
        .IDLE_LEVEL      (1'b1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        address    = a;
        chipselect = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
        check(tag, d, exp);
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check(tag, 32'(irq), 32'(exp));
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;

        // 1. Reset state
        step(3);
        reset_n = 1'b1;
        step(1);
        check_rd("rst_data", 2'd0, 32'h0000_000F);
        check_rd("rst_rsvd", 2'd1, 32'h0000_0000);
        check_rd("rst_mask", 2'd2, 32'h0000_0000);
        check_rd("rst_cap",  2'd3, 32'h0000_0000);
        check_irq("rst_irq", 1'b0);

        // 2. Bit0 falls, accepted exactly 6 edges later, captured one edge after
        in_port = 4'hE;
        step(5);
        check_rd("deb_early", 2'd0, 32'h0000_000F);
        step(1);
        check_rd("deb_accept", 2'd0, 32'h0000_000E);
        check_rd("cap_not_yet", 2'd3, 32'h0000_0000);
        step(1);
        check_rd("cap_bit0", 2'd3, 32'h0000_0001);
        check_irq("irq_masked", 1'b0);
        step(1);
        check_irq("irq_masked2", 1'b0);

        // 3. Clear, release (rising edge ignored), unmask, press again
        bus_write(2'd3, 32'h1);
        check_rd("clr_bit0", 2'd3, 32'h0000_0000);
        in_port = 4'hF;
        step(8);
        check_rd("release", 2'd0, 32'h0000_000F);
        check_rd("rise_ignored", 2'd3, 32'h0000_0000);
        bus_write(2'd2, 32'h1);
        check_rd("mask_wr", 2'd2, 32'h0000_0001);
        check_irq("irq_no_cap", 1'b0);
        in_port = 4'hE;
        step(6);
        check_rd("press2", 2'd0, 32'h0000_000E);
        step(1);
        check_rd("cap2", 2'd3, 32'h0000_0001);
        check_irq("irq_lag", 1'b0);
        step(1);
        check_irq("irq_rise", 1'b1);
        bus_write(2'd3, 32'h1);
        step(1);
        check_irq("irq_fall", 1'b0);
        check_rd("cap_cleared", 2'd3, 32'h0000_0000);

        // 4. Three-cycle glitch on bit1 is rejected
        in_port = 4'hC;
        step(3);
        in_port = 4'hE;
        step(6);
        check_rd("glitch_data", 2'd0, 32'h0000_000E);
        check_rd("glitch_cap",  2'd3, 32'h0000_0000);

        // 5. Clear-all in the same cycle bit2 edge registers: set wins
        in_port = 4'hC;
        step(6);
        check_rd("bit1_accept", 2'd0, 32'h0000_000C);
        step(1);
        check_rd("bit1_cap", 2'd3, 32'h0000_0002);
        check_irq("irq_bit1_masked", 1'b0);
        in_port = 4'h8;
        step(6);
        check_rd("bit2_accept", 2'd0, 32'h0000_0008);
        bus_write(2'd3, 32'hF);
        check_rd("set_wins", 2'd3, 32'h0000_0004);

        // 6. Reset mid-debounce with irq pending
        bus_write(2'd2, 32'h4);
        step(1);
        check_irq("irq_bit2", 1'b1);
        in_port = 4'h0;
        step(3);
        reset_n = 1'b0;
        #1;
        check_irq("rst_irq_async", 1'b0);
        check_rd("rst2_data", 2'd0, 32'h0000_000F);
        check_rd("rst2_mask", 2'd2, 32'h0000_0000);
        check_rd("rst2_cap",  2'd3, 32'h0000_0000);
        in_port = 4'hF;
        step(2);
        reset_n = 1'b1;
        step(10);
        check_rd("post_rst_cap",  2'd3, 32'h0000_0000);
        check_rd("post_rst_data", 2'd0, 32'h0000_000F);
        check_irq("post_rst_irq", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
